spi_ram_responder: RTL and testbench
====================================

# spi_ram_responder

SPI target (responder) implementing a byte-addressed RAM with a 23LC-style command set (READ 0x03, WRITE 0x02, RDSR 0x05). It is the far end of the SPI link that the SoC's SPI controller and memory controller drive for the 0x8000–0xFEFF RAM window. It is used as a synthesizable on-chip stand-in for external SPI RAM and as a loopback target for the SPI controller. All SPI pins are oversampled in the system clock domain; there is no logic clocked by spi_clk.

## Interface
- ADDR_BITS, 8: memory depth is 2^ADDR_BITS bytes; the 16-bit SPI address uses only its low ADDR_BITS bits (aliasing above that).
- SYNC_STAGES, 2: synchronizer flops on spi_cs_n, spi_clk and spi_mosi; minimum 2.

- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- spi_cs_n  in  1  chip select, active low.
- spi_clk  in  1  SPI clock, mode 0 (idle low, sample on rising edge).
- spi_mosi  in  1  controller-to-target data, MSB first.
- spi_miso  out  1  target-to-controller data, MSB first; driven 0 when not shifting read data (no tristate).
- busy  out  1  high while a transaction is active (synchronized CS low).
- cmd_error  out  1  one-clk pulse when an unsupported command byte completes.

## Operation
- Synchronized CS falling edge: enter CMD, clear bit counter, busy=1.
- Synchronized SCK rising edge: shift the synchronized MOSI into rx_shift (MSB first) and increment the 3-bit bit counter. On bit 8 a byte completes.
- Synchronized SCK falling edge: shift tx_shift left; spi_miso = tx_shift[7].
- States:
  - IDLE
  - CMD: byte 0x03→ADDR_HI(read); 0x02→ADDR_HI(write); 0x05→STATUS; any other byte→IGNORE with a cmd_error pulse.
  - ADDR_HI, then ADDR_LO: capture the 16-bit address.
  - READ: on ADDR_LO completion, load tx_shift ← mem[addr]. On each further completed byte, addr+1 and load mem[addr].
  - WRITE: each completed byte writes mem[addr] ← rx_shift, then addr+1.
  - STATUS: tx_shift ← 0x40 (sequential mode) at every byte boundary; MOSI is ignored.
  - IGNORE: spi_miso=0 until CS rises.
- Address arithmetic is modulo 2^ADDR_BITS (0xFF+1→0x00 for the default depth).
- Synchronized CS rising edge, from any state: go to IDLE, busy=0, spi_miso=0. A partial byte is discarded and never written.
- spi_miso is 0 outside READ/STATUS data phases.
- Memory contents are not reset. Reads of never-written locations return X in simulation.

## Timing
- Reset values: spi_miso=0, busy=0, cmd_error=0, state IDLE, address 0, shift registers 0.
- Reset asserted mid-transaction aborts it immediately. No pending write completes.
- Input-to-action latency: SYNC_STAGES+1 clk from a pin edge to the resulting state or register update.
- spi_miso changes at most SYNC_STAGES+1 clk after a spi_clk falling edge. The first read bit is valid SYNC_STAGES+2 clk after the 24th falling edge.
- SPI constraints: spi_clk high and low phases each ≥ SYNC_STAGES+3 clk; CS setup/hold to the first/last SCK edge ≥ SYNC_STAGES+2 clk; CS high ≥ SYNC_STAGES+2 clk between transactions.
- A write to mem occurs in the same clk as byte completion. A READ of the just-written address in a following transaction returns the new value.
- SCK edge coincident with a CS rising edge (same synchronized cycle): the CS rise takes priority and the edge is ignored.

## Configuration
- SPI_RAM_SEQ_EN defined: sequential mode, as described above. Addresses auto-increment, and READ/WRITE continue for any number of bytes until CS rises.
- SPI_RAM_SEQ_EN undefined: byte mode. After the first data byte of a READ or WRITE, the state goes to IGNORE, so further MOSI bytes are discarded and spi_miso=0. RDSR returns 0x00 instead of 0x40.

## Test plan
- Reset: hold rst_n=0 with CS low and toggling SCK → spi_miso=0, busy=0, cmd_error=0; after release, no memory write occurs.
- WRITE then READ: CS low, send 02 00 10 A5, CS high; then send 03 00 10 + one dummy byte → MISO returns 0xA5, busy deasserts within SYNC_STAGES+1 clk of CS high.
- Sequential burst and wrap (SPI_RAM_SEQ_EN): write 02 00 FE 11 22 33, then read 03 00 FE + 3 dummy bytes → 0x11 0x22 0x33, with 0x33 stored at address 0x00. Without the macro: read 03 00 FE + 2 dummy bytes → 0x11 then 0x00, and only 0x11 was stored.
- Unknown command: send 0x9F then 0xFF → cmd_error pulses exactly once, for 1 clk; MISO stays 0; memory unchanged.
- Aborted byte: send 02 00 20 + 5 bits of 0xFF, raise CS → a later read of 0x20 returns the prior value.
- Status: send 05 + 2 dummy bytes → 0x40 0x40 with the macro, 0x00 0x00 without it.

Source files
------------

// File: rtl/spi_ram_responder.sv
// SPI mode-0 target presenting a byte RAM with READ (0x03), WRITE (0x02) and RDSR (0x05); every pin is oversampled on clk.
// Define SPI_RAM_SEQ_EN for sequential (auto-increment burst) mode; left undefined the part runs in byte mode.
module spi_ram_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_cs_n,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic busy,
    output logic cmd_error
);

    localparam int DEPTH = 1 << ADDR_BITS;

`ifdef SPI_RAM_SEQ_EN
    localparam logic       SEQ_MODE   = 1'b1;
    localparam logic [7:0] STATUS_VAL = 8'h40;
`else
    localparam logic       SEQ_MODE   = 1'b0;
    localparam logic [7:0] STATUS_VAL = 8'h00;
`endif

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_READ,
        S_WRITE,
        S_STATUS,
        S_IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   sck_prev_q, sck_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   is_read_q, is_read_d;
    logic                   miso_q, miso_d;
    logic                   cmd_error_q, cmd_error_d;

    logic                   cs_s, sck_s, mosi_s;
    logic                   cs_rise, cs_fall, sck_rise, sck_fall;
    logic [7:0]             rx_next;
    logic [7:0]             mem_rdata;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic                   mem_we;
    logic [7:0]             mem [DEPTH];

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        cs_prev_d   = cs_s;
        sck_prev_d  = sck_s;
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;
    assign rx_next  = {rx_shift_q[6:0], mosi_s};

    // The read port looks ahead: the just-completed low address byte, or the next sequential address.
    assign rd_addr   = (state_q == S_ADDR_LO) ? ADDR_BITS'({addr_q, rx_next}) : addr_q + ADDR_BITS'(1);
    assign mem_rdata = mem[rd_addr];

    // NOTE: every variable gets its hold value before the case below, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        addr_d      = addr_q;
        is_read_d   = is_read_q;
        miso_d      = miso_q;
        cmd_error_d = 1'b0;
        mem_we      = 1'b0;

        if (cs_rise) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else if (cs_fall) begin
            state_d    = S_CMD;
            bit_cnt_d  = 3'd0;
            tx_shift_d = 8'h00;
            miso_d     = 1'b0;
        end else if (state_q != S_IDLE) begin
            if (sck_rise) begin
                rx_shift_d = rx_next;
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    unique case (state_q)
                        S_CMD: begin
                            if (rx_next == CMD_READ) begin
                                is_read_d = 1'b1;
                                state_d   = S_ADDR_HI;
                            end else if (rx_next == CMD_WRITE) begin
                                is_read_d = 1'b0;
                                state_d   = S_ADDR_HI;
                            end else if (rx_next == CMD_RDSR) begin
                                tx_shift_d = STATUS_VAL;
                                state_d    = S_STATUS;
                            end else begin
                                cmd_error_d = 1'b1;
                                miso_d      = 1'b0;
                                state_d     = S_IGNORE;
                            end
                        end
                        S_ADDR_HI: begin
                            addr_d  = ADDR_BITS'(rx_next);
                            state_d = S_ADDR_LO;
                        end
                        S_ADDR_LO: begin
                            addr_d = rd_addr;
                            if (is_read_q) begin
                                tx_shift_d = mem_rdata;
                                state_d    = S_READ;
                            end else begin
                                state_d = S_WRITE;
                            end
                        end
                        S_READ: begin
                            if (SEQ_MODE) begin
                                addr_d     = rd_addr;
                                tx_shift_d = mem_rdata;
                            end else begin
                                miso_d  = 1'b0;
                                state_d = S_IGNORE;
                            end
                        end
                        S_WRITE: begin
                            mem_we = 1'b1;
                            addr_d = addr_q + ADDR_BITS'(1);
                            if (!SEQ_MODE) begin
                                state_d = S_IGNORE;
                            end
                        end
                        S_STATUS: tx_shift_d = STATUS_VAL;
                        default: ;
                    endcase
                end
            end else if (sck_fall) begin
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
                miso_d     = (state_q == S_READ || state_q == S_STATUS) ? tx_shift_q[7] : 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            addr_q      <= '0;
            is_read_q   <= 1'b0;
            miso_q      <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            addr_q      <= addr_d;
            is_read_q   <= is_read_d;
            miso_q      <= miso_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    // NOTE: the RAM array is deliberately left out of reset so it maps onto plain memory; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= rx_next;
        end
    end

    assign spi_miso  = miso_q;
    assign busy      = (state_q != S_IDLE);
    assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: directed vector table, a reset-abort sequence, and random transactions
// checked against a byte-array reference model. Honours SPI_RAM_SEQ_EN like the design.
module tb_spi_ram_responder;

    localparam int SYNC  = 2;
    localparam int HALF  = 6;
    localparam int DEPTH = 256;
`ifdef SPI_RAM_SEQ_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic spi_cs_n;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;
    logic busy;
    logic cmd_error;

    spi_ram_responder #(
        .ADDR_BITS  (8),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .busy     (busy),
        .cmd_error(cmd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // cmd_error monitor: number of pulses and number of high cycles.
    int   err_rise_cnt = 0;
    int   err_cyc_cnt  = 0;
    logic err_prev     = 1'b0;
    always @(posedge clk) begin
        err_prev <= cmd_error;
        if (cmd_error === 1'b1) err_cyc_cnt <= err_cyc_cnt + 1;
        if (cmd_error === 1'b1 && err_prev !== 1'b1) err_rise_cnt <= err_rise_cnt + 1;
    end

    logic [7:0] ref_mem   [DEPTH];
    bit         ref_valid [DEPTH];

    typedef struct {
        string       name;
        int          n;
        int          extra;
        logic [63:0] tx;
        logic [63:0] exp;
        int          err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int n, input int extra,
                                input logic [63:0] tx, input logic [63:0] exp, input int err);
        vec_t v;
        v.name  = name;
        v.n     = n;
        v.extra = extra;
        v.tx    = tx;
        v.exp   = exp;
        v.err   = err;
        return v;
    endfunction

    // Reference: what each full byte should return on MISO, and the effect on memory.
    function automatic void model(input logic [63:0] tx, input int n, output logic [63:0] exp,
                                  output logic [7:0] known, output int err);
        logic [7:0] b [8];
        int base;
        exp   = '0;
        known = '1;
        err   = 0;
        for (int i = 0; i < 8; i++) b[i] = tx[63-8*i -: 8];
        base = int'({b[1], b[2]}) % DEPTH;
        if (n == 0) return;
        case (b[0])
            8'h03: for (int i = 3; i < n; i++) begin
                int a;
                a = (base + i - 3) % DEPTH;
                if (SEQ || i == 3) begin
                    exp[63-8*i -: 8] = ref_mem[a];
                    known[i]         = ref_valid[a];
                end
            end
            8'h02: for (int i = 3; i < n; i++) begin
                int a;
                a = (base + i - 3) % DEPTH;
                if (SEQ || i == 3) begin
                    ref_mem[a]   = b[i];
                    ref_valid[a] = 1'b1;
                end
            end
            8'h05: for (int i = 1; i < n; i++) exp[63-8*i -: 8] = SEQ ? 8'h40 : 8'h00;
            default: err = 1;
        endcase
    endfunction

    // Drives one transaction: n full bytes plus `extra` bits, MSB first, mode 0; MISO sampled at each rising SCK.
    task automatic xfer(input logic [63:0] tx, input int n, input int extra, input bit keep_cs,
                        output logic [63:0] rx);
        int total;
        rx       = '0;
        total    = n * 8 + extra;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check("busy_active", busy, 1);
        for (int k = 0; k < total; k++) begin
            spi_mosi = tx[63-k];
            repeat (HALF) @(negedge clk);
            rx[63-k] = spi_miso;
            spi_clk  = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_clk  = 1'b0;
        end
        spi_mosi = 1'b0;
        if (!keep_cs) begin
            repeat (HALF) @(negedge clk);
            spi_cs_n = 1'b1;
            repeat (SYNC + 1) @(negedge clk);
            check("busy_release", busy, 0);
            check("miso_idle", spi_miso, 0);
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic run_txn(input string name, input logic [63:0] tx, input int n, input int extra,
                           input bit use_tbl, input logic [63:0] tbl_exp, input int tbl_err);
        logic [63:0] mexp;
        logic [63:0] rx;
        logic [7:0]  known;
        int          merr;
        int          r0;
        int          c0;
        model(tx, n, mexp, known, merr);
        if (use_tbl) begin
            mexp  = tbl_exp;
            known = '1;
            merr  = tbl_err;
        end
        r0 = err_rise_cnt;
        c0 = err_cyc_cnt;
        xfer(tx, n, extra, 1'b0, rx);
        for (int i = 0; i < n; i++) begin
            if (known[i]) check($sformatf("%s_b%0d", name, i), rx[63-8*i -: 8], mexp[63-8*i -: 8]);
        end
        check({name, "_err_pulses"}, err_rise_cnt - r0, merr);
        check({name, "_err_cycles"}, err_cyc_cnt - c0, merr);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] scratch;
        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;

        // Reset held with CS low and SCK toggling.
        rst_n    = 1'b0;
        spi_cs_n = 1'b0;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        repeat (6) begin
            repeat (3) @(negedge clk);
            spi_clk = ~spi_clk;
        end
        check("rst_miso", spi_miso, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_error", cmd_error, 0);
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        check("post_rst_busy", busy, 0);

        vecs.push_back(mk("wr_a5",     4, 0, 64'h020010A5_00000000, 64'h0, 0));
        vecs.push_back(mk("rd_a5",     4, 0, 64'h03001000_00000000, 64'h000000A5_00000000, 0));
        vecs.push_back(mk("wr_00",     4, 0, 64'h0200005A_00000000, 64'h0, 0));
        vecs.push_back(mk("wr_ff",     4, 0, 64'h0200FF77_00000000, 64'h0, 0));
        vecs.push_back(mk("wr_burst",  6, 0, 64'h0200FE11_22330000, 64'h0, 0));
        vecs.push_back(mk("rd_burst",  6, 0, 64'h0300FE00_00000000,
                          SEQ ? 64'h00000011_22330000 : 64'h00000011_00000000, 0));
        vecs.push_back(mk("rd_alias0", 4, 0, 64'h03120000_00000000,
                          SEQ ? 64'h00000033_00000000 : 64'h0000005A_00000000, 0));
        vecs.push_back(mk("rd_ff",     4, 0, 64'h0300FF00_00000000,
                          SEQ ? 64'h00000022_00000000 : 64'h00000077_00000000, 0));
        vecs.push_back(mk("bad_cmd",   2, 0, 64'h9FFF0000_00000000, 64'h0, 1));
        vecs.push_back(mk("status",    3, 0, 64'h05000000_00000000,
                          SEQ ? 64'h00404000_00000000 : 64'h0, 0));
        vecs.push_back(mk("wr_20",     4, 0, 64'h0200203C_00000000, 64'h0, 0));
        vecs.push_back(mk("wr_abort",  3, 5, 64'h020020FF_00000000, 64'h0, 0));
        vecs.push_back(mk("rd_20",     4, 0, 64'h03002000_00000000, 64'h0000003C_00000000, 0));

        foreach (vecs[i]) begin
            run_txn(vecs[i].name, vecs[i].tx, vecs[i].n, vecs[i].extra, 1'b1, vecs[i].exp, vecs[i].err);
        end

        // Reset during the last bit of a pending write must not let it land.
        run_txn("wr_30", 64'h020030C3_00000000, 4, 0, 1'b1, 64'h0, 0);
        xfer(64'h02003099_00000000, 3, 7, 1'b1, scratch);
        rst_n = 1'b0;
        repeat (3) begin
            spi_clk = 1'b1;
            repeat (3) @(negedge clk);
            spi_clk = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("midrst_miso", spi_miso, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_error", cmd_error, 0);
        spi_cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        run_txn("rd_30", 64'h03003000_00000000, 4, 0, 1'b1, 64'h000000C3_00000000, 0);

        // Random traffic against the reference model.
        begin
            logic [15:0] last_addr;
            last_addr = 16'h0010;
            for (int t = 0; t < 24; t++) begin
                logic [63:0] tx;
                logic [15:0] a;
                logic [7:0]  c;
                int          op;
                int          nd;
                int          n;
                int          extra;
                tx    = '0;
                extra = 0;
                op    = $urandom_range(0, 4);
                nd    = $urandom_range(1, 3);
                if (op <= 1) begin
                    a          = 16'($urandom);
                    tx[63:40]  = {8'h02, a};
                    for (int d = 0; d < nd; d++) tx[39-8*d -: 8] = 8'($urandom);
                    n          = 3 + nd;
                    last_addr  = a;
                    if ($urandom_range(0, 3) == 0) begin
                        extra             = $urandom_range(1, 7);
                        tx[63-8*n -: 8]   = 8'($urandom);
                    end
                end else if (op <= 3) begin
                    a         = {8'($urandom), last_addr[7:0] + 8'($urandom_range(0, 2))};
                    tx[63:40] = {8'h03, a};
                    n         = 3 + nd;
                end else if ($urandom_range(0, 1) == 1) begin
                    tx[63:56] = 8'h05;
                    n         = 1 + nd;
                end else begin
                    c = 8'($urandom);
                    if (c == 8'h02 || c == 8'h03 || c == 8'h05) c = c | 8'h80;
                    tx[63:48] = {c, 8'($urandom)};
                    n         = 2;
                end
                run_txn($sformatf("rnd%0d", t), tx, n, extra, 1'b0, 64'h0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
